// File: rtl/i2c_scl_phase_generator.sv
// SCL waveform generator: four quarter-period phases with one-cycle strobes, clock stretching and an optional stretch timeout.
// All outputs are registered, so a start is seen one cycle later; a slave holding SCL low stalls the HIGH_A count.
module i2c_scl_phase_generator #(
  parameter int CNT_WIDTH      = 16,
  parameter int STRETCH_WIDTH  = 20,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 StartStop,
  input  logic [CNT_WIDTH-1:0] QuarterPeriod,
  input  logic                 SclIn,
  output logic                 SignalOut,
  output logic                 Busy,
  output logic                 FallTick,
  output logic                 LowMidTick,
  output logic                 RiseTick,
  output logic                 HighMidTick,
  output logic                 Stretching,
  output logic                 Timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIGH_A = 3'd1,
    HIGH_B = 3'd2,
    LOW_A  = 3'd3,
    LOW_B  = 3'd4
  } state_t;

  localparam bit                       TimeoutEnabled = (TIMEOUT_CYCLES != 0);
  localparam logic [STRETCH_WIDTH-1:0] TimeoutLast    = STRETCH_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic [CNT_WIDTH-1:0]     count;
  logic [CNT_WIDTH-1:0]     quarter;
  logic [STRETCH_WIDTH-1:0] stretchCnt;

  logic phaseEnd;
  logic stretchSaturated;
  logic timeoutHit;

  assign phaseEnd         = (count == quarter);
  assign stretchSaturated = &stretchCnt;
  // The stretch cycle being sampled now is the one that reaches the limit.
  assign timeoutHit       = TimeoutEnabled && (stretchCnt == TimeoutLast);

  always_ff @(posedge clock) begin
    if (Reset) begin
      state       <= IDLE;
      count       <= '0;
      quarter     <= '0;
      stretchCnt  <= '0;
      SignalOut   <= 1'b1;
      Busy        <= 1'b0;
      FallTick    <= 1'b0;
      LowMidTick  <= 1'b0;
      RiseTick    <= 1'b0;
      HighMidTick <= 1'b0;
      Stretching  <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      FallTick    <= 1'b0;
      LowMidTick  <= 1'b0;
      RiseTick    <= 1'b0;
      HighMidTick <= 1'b0;
      Stretching  <= 1'b0;

      case (state)
        IDLE: begin
          SignalOut <= 1'b1;
          Busy      <= 1'b0;
          if (StartStop) begin
            state      <= HIGH_A;
            Busy       <= 1'b1;
            Timeout    <= 1'b0;
            quarter    <= QuarterPeriod;
            count      <= '0;
            stretchCnt <= '0;
          end
        end

        HIGH_A: begin
          if (SclIn) begin
            if (phaseEnd) begin
              state       <= HIGH_B;
              count       <= '0;
              HighMidTick <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (timeoutHit) begin
            state     <= IDLE;
            count     <= '0;
            SignalOut <= 1'b1;
            Busy      <= 1'b0;
            Timeout   <= 1'b1;
          end else begin
            Stretching <= 1'b1;
            if (!stretchSaturated) begin
              stretchCnt <= stretchCnt + 1'b1;
            end
          end
        end

        HIGH_B: begin
          if (phaseEnd) begin
            count <= '0;
            if (StartStop) begin
              state     <= LOW_A;
              SignalOut <= 1'b0;
              FallTick  <= 1'b1;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        LOW_A: begin
          if (phaseEnd) begin
            state      <= LOW_B;
            count      <= '0;
            LowMidTick <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        LOW_B: begin
          if (phaseEnd) begin
            state      <= HIGH_A;
            count      <= '0;
            stretchCnt <= '0;
            SignalOut  <= 1'b1;
            RiseTick   <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          count     <= '0;
          SignalOut <= 1'b1;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_phase_generator.sv
// Randomised bench: an arithmetic timeline model of the SCL phases is compared event-by-event with the DUT.
module tb_i2c_scl_phase_generator;
  localparam int TMO = 10;

  // Event codes: relCycle*16 + type
  // 0 SCL low, 1 SCL high, 2 FallTick, 3 LowMidTick, 4 RiseTick, 5 HighMidTick,
  // 6 Stretching, 7 Busy rise, 8 Busy fall, 9 Timeout rise, 10 Timeout fall
  logic        clock = 1'b0;
  logic        Reset, StartStop, SclIn, hold;
  logic [15:0] QuarterPeriod;
  logic        SignalOut, Busy, FallTick, LowMidTick, RiseTick, HighMidTick, Stretching, Timeout;

  int vectors = 0;
  int miscompares = 0;
  int expEv[$];
  int obsEv[$];
  bit tmoPending = 1'b0;

  always #5 clock = ~clock;
  assign SclIn = SignalOut & ~hold;

  i2c_scl_phase_generator #(
    .CNT_WIDTH(16),
    .STRETCH_WIDTH(20),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .StartStop(StartStop),
    .QuarterPeriod(QuarterPeriod),
    .SclIn(SclIn),
    .SignalOut(SignalOut),
    .Busy(Busy),
    .FallTick(FallTick),
    .LowMidTick(LowMidTick),
    .RiseTick(RiseTick),
    .HighMidTick(HighMidTick),
    .Stretching(Stretching),
    .Timeout(Timeout)
  );

  // Builds the expected timeline from phase arithmetic, then drives one start..stop run.
  // dropMode: 0 random legal drop, 1 middle of the last LOW_A, 2 latest legal drop.
  task automatic run_seq(input int q, input int qAfter, input int nHigh, input int str [8], input int dropMode);
    int  t, hbEnd, prevHbEnd, lo, hi, lastLa, endRel, d, nUsed;
    int  haRel [8];
    bit  done, tmoNext, pSig, pBusy, pTmo;
    expEv.delete();
    obsEv.delete();
    t = 1; prevHbEnd = 0; lo = 1; hi = 1; lastLa = -1; endRel = 2; nUsed = 0;
    done = 1'b0; tmoNext = 1'b0;
    for (int m = 0; m < nHigh && !done; m++) begin
      haRel[m] = t;
      nUsed = m + 1;
      if (m == 0) begin
        expEv.push_back(t*16 + 7);
        if (tmoPending) expEv.push_back(t*16 + 10);
      end else begin
        expEv.push_back(t*16 + 1);
        expEv.push_back(t*16 + 4);
      end
      if (str[m] >= TMO) begin
        for (int k = 1; k < TMO; k++) expEv.push_back((t+k)*16 + 6);
        expEv.push_back((t+TMO)*16 + 8);
        expEv.push_back((t+TMO)*16 + 9);
        lo = prevHbEnd + 1; hi = t + TMO - 1; endRel = t + TMO;
        tmoNext = 1'b1; done = 1'b1;
      end else begin
        for (int k = 1; k <= str[m]; k++) expEv.push_back((t+k)*16 + 6);
        t = t + str[m] + q + 1;
        expEv.push_back(t*16 + 5);
        hbEnd = t + q;
        if (m == nHigh - 1) begin
          expEv.push_back((hbEnd+1)*16 + 8);
          lo = prevHbEnd + 1; hi = hbEnd; endRel = hbEnd + 1; done = 1'b1;
        end else begin
          t = hbEnd + 1;
          lastLa = t;
          expEv.push_back(t*16 + 0);
          expEv.push_back(t*16 + 2);
          t = t + q + 1;
          expEv.push_back(t*16 + 3);
          t = t + q + 1;
          prevHbEnd = hbEnd;
        end
      end
    end
    case (dropMode)
      1:       d = (lastLa >= 0) ? lastLa + q/2 : lo;
      2:       d = hi;
      default: d = int'($urandom_range(hi, lo));
    endcase

    pSig = SignalOut; pBusy = Busy; pTmo = Timeout;
    for (int c = 0; c <= endRel + 2; c++) begin
      if (c > 0) begin
        @(negedge clock);
        if (pSig === 1'b1 && SignalOut === 1'b0) obsEv.push_back(c*16 + 0);
        if (pSig === 1'b0 && SignalOut === 1'b1) obsEv.push_back(c*16 + 1);
        if (FallTick === 1'b1)    obsEv.push_back(c*16 + 2);
        if (LowMidTick === 1'b1)  obsEv.push_back(c*16 + 3);
        if (RiseTick === 1'b1)    obsEv.push_back(c*16 + 4);
        if (HighMidTick === 1'b1) obsEv.push_back(c*16 + 5);
        if (Stretching === 1'b1)  obsEv.push_back(c*16 + 6);
        if (pBusy === 1'b0 && Busy === 1'b1)   obsEv.push_back(c*16 + 7);
        if (pBusy === 1'b1 && Busy === 1'b0)   obsEv.push_back(c*16 + 8);
        if (pTmo === 1'b0 && Timeout === 1'b1) obsEv.push_back(c*16 + 9);
        if (pTmo === 1'b1 && Timeout === 1'b0) obsEv.push_back(c*16 + 10);
      end
      pSig = SignalOut; pBusy = Busy; pTmo = Timeout;
      StartStop     = (c < d);
      QuarterPeriod = (c == 0) ? 16'(q) : 16'(qAfter);
      hold = 1'b0;
      for (int m = 0; m < nUsed; m++)
        if (c >= haRel[m] && c < haRel[m] + str[m]) hold = 1'b1;
    end
    hold = 1'b0;
    StartStop = 1'b0;
    expEv.sort();
    obsEv.sort();
    tmoPending = tmoNext;
  endtask

  task automatic test_reset();
    Reset = 1'b1; StartStop = 1'b0; QuarterPeriod = '0; hold = 1'b0;
    repeat (3) @(negedge clock);
    vectors++; if (SignalOut !== 1'b1)   begin miscompares++; $display("FAIL reset SignalOut: got %b, expected 1", SignalOut); end
    vectors++; if (Busy !== 1'b0)        begin miscompares++; $display("FAIL reset Busy: got %b, expected 0", Busy); end
    vectors++; if (FallTick !== 1'b0)    begin miscompares++; $display("FAIL reset FallTick: got %b, expected 0", FallTick); end
    vectors++; if (LowMidTick !== 1'b0)  begin miscompares++; $display("FAIL reset LowMidTick: got %b, expected 0", LowMidTick); end
    vectors++; if (RiseTick !== 1'b0)    begin miscompares++; $display("FAIL reset RiseTick: got %b, expected 0", RiseTick); end
    vectors++; if (HighMidTick !== 1'b0) begin miscompares++; $display("FAIL reset HighMidTick: got %b, expected 0", HighMidTick); end
    vectors++; if (Stretching !== 1'b0)  begin miscompares++; $display("FAIL reset Stretching: got %b, expected 0", Stretching); end
    vectors++; if (Timeout !== 1'b0)     begin miscompares++; $display("FAIL reset Timeout: got %b, expected 0", Timeout); end
    Reset = 1'b0;
    @(negedge clock);
    tmoPending = 1'b0;
  endtask

  task automatic test_free_run();
    int str [8];
    int got, f1, f2;
    str = '{default: 0};
    run_seq(4, 4, 4, str, 0);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL free_run count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL free_run ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    f1 = -1; f2 = -1;
    foreach (obsEv[i]) if ((obsEv[i] & 15) == 2) begin
      if (f1 < 0) f1 = obsEv[i] >>> 4; else if (f2 < 0) f2 = obsEv[i] >>> 4;
    end
    vectors++; if (f1 !== 11)      begin miscompares++; $display("FAIL free_run first_fall: got %0d, expected 11", f1); end
    vectors++; if (f2 - f1 !== 20) begin miscompares++; $display("FAIL free_run period: got %0d, expected 20", f2 - f1); end
  endtask

  task automatic test_stretch();
    int str [8];
    int got, r, h, ns;
    str = '{default: 0};
    str[1] = 7;
    run_seq(4, 4, 3, str, 0);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL stretch count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL stretch ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    r = -1; h = -1; ns = 0;
    foreach (obsEv[i]) begin
      if ((obsEv[i] & 15) == 4 && r < 0) r = obsEv[i] >>> 4;
      if ((obsEv[i] & 15) == 5 && r >= 0 && h < 0) h = obsEv[i] >>> 4;
      if ((obsEv[i] & 15) == 6) ns++;
    end
    vectors++; if (h - r !== 12) begin miscompares++; $display("FAIL stretch rise_to_highmid: got %0d, expected 12", h - r); end
    vectors++; if (ns !== 7)     begin miscompares++; $display("FAIL stretch cycles: got %0d, expected 7", ns); end
  endtask

  task automatic test_graceful_stop();
    int str [8];
    int got, nf;
    str = '{default: 0};
    run_seq(4, 4, 2, str, 1);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL graceful_stop count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL graceful_stop ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    nf = 0;
    foreach (obsEv[i]) if ((obsEv[i] & 15) == 2) nf++;
    vectors++; if (nf !== 1)           begin miscompares++; $display("FAIL graceful_stop falls: got %0d, expected 1", nf); end
    vectors++; if (SignalOut !== 1'b1) begin miscompares++; $display("FAIL graceful_stop park: got %b, expected 1", SignalOut); end
  endtask

  task automatic test_timeout();
    int str [8];
    int got;
    str = '{default: 0};
    str[1] = TMO + 5;
    run_seq(4, 4, 2, str, 0);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL timeout count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL timeout ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    repeat (3) @(negedge clock);
    vectors++; if (Timeout !== 1'b1)   begin miscompares++; $display("FAIL timeout sticky: got %b, expected 1", Timeout); end
    vectors++; if (Busy !== 1'b0)      begin miscompares++; $display("FAIL timeout busy: got %b, expected 0", Busy); end
    vectors++; if (SignalOut !== 1'b1) begin miscompares++; $display("FAIL timeout park: got %b, expected 1", SignalOut); end
  endtask

  task automatic test_q_change();
    int str [8];
    int got, f1, f2;
    str = '{default: 0};
    run_seq(4, 9, 3, str, 0);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL q_change count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL q_change ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    run_seq(9, int'($urandom_range(0, 15)), 3, str, 0);
    f1 = -1; f2 = -1;
    foreach (obsEv[i]) if ((obsEv[i] & 15) == 2) begin
      if (f1 < 0) f1 = obsEv[i] >>> 4; else if (f2 < 0) f2 = obsEv[i] >>> 4;
    end
    vectors++; if (f2 - f1 !== 40) begin miscompares++; $display("FAIL q_change new_period: got %0d, expected 40", f2 - f1); end
  endtask

  task automatic test_reset_mid_run();
    int str [8];
    int got, f, r;
    StartStop = 1'b1; QuarterPeriod = 16'd3; hold = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c == 14) begin
        vectors++; if (SignalOut !== 1'b0) begin miscompares++; $display("FAIL mid_reset pre_low: got %b, expected 0", SignalOut); end
        vectors++; if (Busy !== 1'b1)      begin miscompares++; $display("FAIL mid_reset pre_busy: got %b, expected 1", Busy); end
      end
    end
    Reset = 1'b1; StartStop = 1'b0;
    @(negedge clock);
    vectors++; if (SignalOut !== 1'b1) begin miscompares++; $display("FAIL mid_reset SignalOut: got %b, expected 1", SignalOut); end
    vectors++; if (Busy !== 1'b0)      begin miscompares++; $display("FAIL mid_reset Busy: got %b, expected 0", Busy); end
    vectors++; if ({FallTick, LowMidTick, RiseTick, HighMidTick, Stretching, Timeout} !== 6'b0)
      begin miscompares++; $display("FAIL mid_reset ticks: got %b, expected 000000", {FallTick, LowMidTick, RiseTick, HighMidTick, Stretching, Timeout}); end
    Reset = 1'b0;
    @(negedge clock);
    tmoPending = 1'b0;
    str = '{default: 0};
    run_seq(0, int'($urandom_range(0, 15)), 3, str, 0);
    vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL q0 count: got %0d events, expected %0d", obsEv.size(), expEv.size()); end
    for (int i = 0; i < expEv.size(); i++) begin
      vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
      if (got !== expEv[i]) begin miscompares++; $display("FAIL q0 ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
    end
    f = -1; r = -1;
    foreach (obsEv[i]) begin
      if ((obsEv[i] & 15) == 2 && f < 0) f = obsEv[i] >>> 4;
      if ((obsEv[i] & 15) == 4 && r < 0) r = obsEv[i] >>> 4;
    end
    vectors++; if (f !== 3) begin miscompares++; $display("FAIL q0 first_fall: got %0d, expected 3", f); end
    vectors++; if (r !== 5) begin miscompares++; $display("FAIL q0 first_rise: got %0d, expected 5", r); end
  endtask

  task automatic test_random();
    int str [8];
    int got, q, nh;
    for (int it = 0; it < 14; it++) begin
      q  = int'($urandom_range(0, 5));
      nh = int'($urandom_range(1, 4));
      str = '{default: 0};
      for (int m = 0; m < nh; m++)
        str[m] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
      if ($urandom_range(0, 5) == 0) str[nh-1] = TMO + 2;
      run_seq(q, int'($urandom_range(0, 15)), nh, str, int'($urandom_range(0, 2)) == 2 ? 2 : 0);
      vectors++; if (obsEv.size() != expEv.size()) begin miscompares++; $display("FAIL random%0d count: got %0d events, expected %0d", it, obsEv.size(), expEv.size()); end
      for (int i = 0; i < expEv.size(); i++) begin
        vectors++; got = (i < obsEv.size()) ? obsEv[i] : -16;
        if (got !== expEv[i]) begin miscompares++; $display("FAIL random%0d ev%0d: got cyc %0d type %0d, expected cyc %0d type %0d", it, i, got >>> 4, got & 15, expEv[i] >>> 4, expEv[i] & 15); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stretch();
    test_graceful_stop();
    test_timeout();
    test_q_change();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
